w_bit_sequencer: RTL

- Upstream stage for the serial sequence-detector FSM: supplies its input bit `w` one bit per user step.
- Captures a WIDTH-bit pattern from the switches on a debounced `load` button.
- Shifts the pattern out MSB-first, one bit per debounced `step` button press.
- Each new bit is flagged with a one-cycle `w_valid` strobe, which the downstream FSM uses as its state-advance enable.

---
 rtl/w_bit_sequencer.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/w_bit_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : w_bit_sequencer
// Brief    : Upstream bit source for the serial sequence-detector FSM.
//            Captures a WIDTH-bit switch pattern on a debounced load press
//            and shifts it out MSB-first, one bit per debounced step press,
//            flagging each new bit with a one-cycle w_valid_o strobe.
// Options  : define W_SEQ_LOOP_EN to make the pattern repeat endlessly
//            (done_o pulses once per pass instead of latching).
// Revision : 1.0 - initial release
// ============================================================================
module w_bit_sequencer #(
  parameter int WIDTH           = 8,   // pattern length, 2..16
  parameter int DEBOUNCE_CYCLES = 16   // stable samples before a level change
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] pattern_i,
  input  logic             load_btn_i,
  input  logic             step_btn_i,
  output logic             w_o,
  output logic             w_valid_o,
  output logic [4:0]       bits_left_o,
  output logic             done_o
);

  localparam int             CNT_W    = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [4:0]     FULL_CNT = 5'(WIDTH);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READY = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Index 0 = load button, index 1 = step button.
  logic [1:0] btn_raw;
  logic [1:0] btn_pulse;
  assign btn_raw = {step_btn_i, load_btn_i};

  genvar gi;
  for (gi = 0; gi < 2; gi++) begin : g_btn
    logic             sync1_q;
    logic             sync2_q;
    logic             deb_q;
    logic             deb_prev_q;
    logic [CNT_W-1:0] cnt_q;

    // Synchronize, then only accept a new level once it has been held
    // for DEBOUNCE_CYCLES consecutive synchronized samples.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync1_q    <= 1'b0;
        sync2_q    <= 1'b0;
        deb_q      <= 1'b0;
        deb_prev_q <= 1'b0;
        cnt_q      <= '0;
      end else begin
        sync1_q    <= btn_raw[gi];
        sync2_q    <= sync1_q;
        deb_prev_q <= deb_q;
        if (sync2_q == deb_q) begin
          cnt_q <= '0;
        end else if (cnt_q == CNT_MAX) begin
          deb_q <= sync2_q;
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end
    end

    assign btn_pulse[gi] = deb_q & ~deb_prev_q;
  end

  logic load_p;
  logic step_p;
  assign load_p = btn_pulse[0];
  assign step_p = btn_pulse[1];

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] held_q, held_d;
  logic             w_q, w_d;
  logic             w_valid_q, w_valid_d;
  logic [4:0]       bits_left_q, bits_left_d;
  logic             done_q, done_d;

  // In loop mode the cycle after the emptying step refills from the held copy.
  logic reload;
`ifdef W_SEQ_LOOP_EN
  assign reload = (state_q == ST_SHIFT) && (bits_left_q == 5'd0);
`else
  assign reload = 1'b0;
`endif

  // Next-state logic: load has priority and swallows a coincident step.
  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    held_d      = held_q;
    w_d         = w_q;
    w_valid_d   = 1'b0;
    bits_left_d = bits_left_q;
    done_d      = done_q;
    if (load_p) begin
      shreg_d     = pattern_i;
      held_d      = pattern_i;
      bits_left_d = FULL_CNT;
      done_d      = 1'b0;
      state_d     = ST_READY;
    end else if (reload) begin
      shreg_d     = held_q;
      bits_left_d = FULL_CNT;
      done_d      = 1'b0;
    end else if (step_p && ((state_q == ST_READY) || (state_q == ST_SHIFT)) &&
                 (bits_left_q != 5'd0)) begin
      w_d         = shreg_q[WIDTH-1];
      shreg_d     = {shreg_q[WIDTH-2:0], 1'b0};
      bits_left_d = bits_left_q - 5'd1;
      w_valid_d   = 1'b1;
      if (bits_left_q == 5'd1) begin
        done_d = 1'b1;
`ifdef W_SEQ_LOOP_EN
        state_d = ST_SHIFT;
`else
        state_d = ST_DONE;
`endif
      end else begin
        state_d = ST_SHIFT;
      end
    end
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      shreg_q     <= '0;
      held_q      <= '0;
      w_q         <= 1'b0;
      w_valid_q   <= 1'b0;
      bits_left_q <= 5'd0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      held_q      <= held_d;
      w_q         <= w_d;
      w_valid_q   <= w_valid_d;
      bits_left_q <= bits_left_d;
      done_q      <= done_d;
    end
  end

  assign w_o         = w_q;
  assign w_valid_o   = w_valid_q;
  assign bits_left_o = bits_left_q;
  assign done_o      = done_q;

endmodule
`default_nettype wire
